cpu_irq_controller: RTL and testbench
=====================================

# cpu_irq_controller

Interrupt controller that collects external interrupt lines, tracks pending/enable state per source and raises a single prioritised request with a cause code to the CPU exception stage. It is the requesting end of the CPU interrupt handshake: the CPU acknowledges when it vectors to `intvec` and signals completion when RTI retires. Software programs and inspects it through a small memory-mapped register port on the peripheral bus.

## Interface
- `NUM_SRC`, 8: number of interrupt sources, 1..16.
- `clock`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `irq_src`  in  NUM_SRC  raw interrupt lines, asynchronous to `clock`.
- `bus_req`  in  1  register access strobe, one cycle.
- `bus_write`  in  1  1 = write, 0 = read.
- `bus_addr`  in  4  word offset: 0 PENDING, 1 ENABLE, 2 EDGE, 3 STATUS.
- `bus_wdata`  in  32  write data.
- `bus_rdata`  out  32  read data, valid with `bus_ack`.
- `bus_ack`  out  1  access complete, one cycle after `bus_req`.
- `cpu_irq`  out  1  interrupt request to the CPU.
- `cpu_irq_cause`  out  8  cause code, stable while `cpu_irq`=1.
- `cpu_irq_ack`  in  1  CPU took the interrupt (non-stalled P4 cycle).
- `cpu_irq_done`  in  1  CPU retired RTI.

## Operation
- Each source is synchronised with 2 flops, then conditioned. If EDGE[i]=1, a rising edge sets PENDING[i]. If EDGE[i]=0, PENDING[i] follows the synchronised level.
- Register semantics:
  - PENDING: read gives the pending bits. A write of 1 clears an edge bit (W1C) and is ignored for level bits.
  - ENABLE and EDGE: read/write, bits [NUM_SRC-1:0]. Upper bits read 0.
  - STATUS: read gives {22'h0, state[1:0], active_id[3:0], 4'h0}. Writes are ignored.
- Priority: the lowest index among PENDING & ENABLE wins.
- FSM states:
  - IDLE: `cpu_irq`=0. When any PENDING & ENABLE bit is set, latch `active_id` = the winner, set cause = 8'h10 + `active_id`, and go to REQUEST.
  - REQUEST: `cpu_irq`=1 and the cause is held. On `cpu_irq_ack`, clear PENDING[`active_id`] if it is an edge source, then go to IN_SERVICE. The request is never withdrawn: a level source dropping or being disabled does not deassert `cpu_irq`.
  - IN_SERVICE: `cpu_irq`=0. On `cpu_irq_done`, go to IDLE. Nested interrupts are not supported.
- `cpu_irq_ack` outside REQUEST and `cpu_irq_done` outside IN_SERVICE are ignored.

## Timing
- Reset values:
  - `cpu_irq`=0, `cpu_irq_cause`=8'h00, `bus_ack`=0, `bus_rdata`=0.
  - PENDING=0, ENABLE=0, EDGE=0, state=IDLE, synchroniser flops=0.
- Source to request: a rising edge on `irq_src[i]` sampled at clock edge 0 reaches the synchroniser output at edge 2. PENDING is set at edge 3. `cpu_irq` is asserted after edge 4.
- Ack: `cpu_irq` deasserts on the cycle following the ack edge. A re-request needs `cpu_irq_done` first; the earliest re-assertion is the cycle after the done edge.
- Bus: `bus_ack` and `bus_rdata` are registered, one cycle after `bus_req`. Writes take effect at the `bus_req` edge.
- Simultaneous events:
  - A W1C write and a new edge on the same bit in the same cycle: set wins.
  - An ack clear and a new edge on the active source in the same cycle: set wins.
  - An ENABLE write in the cycle an IDLE→REQUEST decision is made: the decision uses the pre-write ENABLE.
- A reset mid-handshake returns to IDLE and drops `cpu_irq` at the next edge.

## Structure
- Shared header `cpu.vh` gains:
  - `IRQ_REG_PENDING`/`ENABLE`/`EDGE`/`STATUS` offsets.
  - `CAUSE_IRQ_BASE` (8'h10).
  - `IRQ_ST_IDLE`/`REQUEST`/`IN_SERVICE` encodings (2'd0/1/2).
- Sub-module `irq_sync_edge`: 2-flop synchroniser plus rising-edge detect, instantiated once per source. The top level holds the registers, priority encoder and FSM.

## Test plan
- Edge source 3: ENABLE=0x08, EDGE=0x08, pulse `irq_src[3]` for 1 cycle → `cpu_irq`=1 at cycle 4 with cause 8'h13. Ack → PENDING reads 0x00. Done → IDLE.
- Priority: level sources 5 and 2 both high, ENABLE=0xFF → cause 8'h12. After ack and done with source 2 dropped → next cause 8'h15.
- Masking: pending source 1 with ENABLE=0 → `cpu_irq` stays 0 and PENDING reads 0x02. Write ENABLE=0x02 → `cpu_irq` asserts 2 cycles later.
- Simultaneous set/clear: W1C write of 0x01 in the same cycle as a new edge on source 0 → PENDING bit 0 remains 1.
- Held request: level source 4 drops while in REQUEST → `cpu_irq` stays 1 and cause stays 8'h14 until ack. A spurious `cpu_irq_done` in REQUEST is ignored.
- Reset: assert `reset_n`=0 for 1 cycle while in IN_SERVICE → all registers read 0, STATUS state=0, `cpu_irq`=0.

Source files
------------

// File: rtl/cpu_irq_controller_pkg.sv
// Shared constants, FSM encoding and priority helper for the CPU interrupt controller.
package cpu_irq_controller_pkg;

  localparam logic [3:0] IRQ_REG_PENDING = 4'd0;
  localparam logic [3:0] IRQ_REG_ENABLE  = 4'd1;
  localparam logic [3:0] IRQ_REG_EDGE    = 4'd2;
  localparam logic [3:0] IRQ_REG_STATUS  = 4'd3;

  localparam logic [7:0] CAUSE_IRQ_BASE = 8'h10;

  localparam logic [1:0] IRQ_ST_IDLE       = 2'd0;
  localparam logic [1:0] IRQ_ST_REQUEST    = 2'd1;
  localparam logic [1:0] IRQ_ST_IN_SERVICE = 2'd2;

  typedef enum logic [1:0] {
    StIdle      = IRQ_ST_IDLE,
    StRequest   = IRQ_ST_REQUEST,
    StInService = IRQ_ST_IN_SERVICE
  } irq_state_e;

  // Lowest set index wins; 0 when nothing is set (caller qualifies with |req).
  function automatic logic [3:0] lowest_id(input logic [15:0] req);
    lowest_id = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (req[i]) lowest_id = 4'(i);
    end
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one interrupt line, followed by a registered level
// and a registered one-cycle rising-edge pulse.
module irq_sync_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic sync1_q, sync2_q, level_q, rise_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      level_q <= sync2_q;
      rise_q  <= sync2_q & ~level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/cpu_irq_controller.sv
// Interrupt controller: per-source pending/enable/edge registers, lowest-index
// priority and a request/ack/done handshake with the CPU exception stage.
module cpu_irq_controller
  import cpu_irq_controller_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               bus_req,
  input  logic               bus_write,
  input  logic [3:0]         bus_addr,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic               bus_ack,
  output logic               cpu_irq,
  output logic [7:0]         cpu_irq_cause,
  input  logic               cpu_irq_ack,
  input  logic               cpu_irq_done
);

  logic [NUM_SRC-1:0] src_level, src_rise;
  logic [NUM_SRC-1:0] pend_q, pend_d, en_q, edge_q;
  logic [NUM_SRC-1:0] w1c, ack_clr;
  logic [15:0]        req16;
  logic [3:0]         win_id, id_q, id_d;
  logic [7:0]         cause_q, cause_d;
  irq_state_e         state_q, state_d;
  logic               wr;
  logic [31:0]        rd_data, rdata_q;
  logic               ack_q;
  logic               unused_wdata;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_sync_edge u_sync (
      .clock    (clock),
      .reset_n  (reset_n),
      .async_in (irq_src[g]),
      .level    (src_level[g]),
      .rise     (src_rise[g])
    );
  end

  assign wr           = bus_req & bus_write;
  assign unused_wdata = ^bus_wdata[31:NUM_SRC];

  // Edge bits: a new rise beats any clear (W1C or ack) in the same cycle.
  always_comb begin
    w1c     = '0;
    ack_clr = '0;
    if (wr && bus_addr == IRQ_REG_PENDING) w1c = bus_wdata[NUM_SRC-1:0];
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_clr[i] = (state_q == StRequest) && cpu_irq_ack && (id_q == 4'(i));
    end
    pend_d = (edge_q & ((pend_q & ~(w1c | ack_clr)) | src_rise)) | (~edge_q & src_level);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pend_q <= '0;
      en_q   <= '0;
      edge_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (wr && bus_addr == IRQ_REG_ENABLE) en_q <= bus_wdata[NUM_SRC-1:0];
      if (wr && bus_addr == IRQ_REG_EDGE)   edge_q <= bus_wdata[NUM_SRC-1:0];
    end
  end

  assign req16  = 16'(pend_q & en_q);
  assign win_id = lowest_id(req16);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cause_d = cause_q;
    unique case (state_q)
      StIdle: begin
        if (|req16) begin
          id_d    = win_id;
          cause_d = CAUSE_IRQ_BASE + {4'h0, win_id};
          state_d = StRequest;
        end
      end
      StRequest: begin
        if (cpu_irq_ack) state_d = StInService;
      end
      StInService: begin
        if (cpu_irq_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      id_q    <= 4'd0;
      cause_q <= 8'h00;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cause_q <= cause_d;
    end
  end

  assign cpu_irq       = (state_q == StRequest);
  assign cpu_irq_cause = cause_q;

  always_comb begin
    rd_data = '0;
    case (bus_addr)
      IRQ_REG_PENDING: rd_data[NUM_SRC-1:0] = pend_q;
      IRQ_REG_ENABLE:  rd_data[NUM_SRC-1:0] = en_q;
      IRQ_REG_EDGE:    rd_data[NUM_SRC-1:0] = edge_q;
      IRQ_REG_STATUS:  rd_data = {22'h0, state_q, id_q, 4'h0};
      default:         rd_data = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= bus_req;
      rdata_q <= (bus_req && !bus_write) ? rd_data : '0;
    end
  end

  assign bus_ack   = ack_q;
  assign bus_rdata = rdata_q;

endmodule

// File: tb/tb_cpu_irq_controller.sv
// Directed bench for cpu_irq_controller: one task per scenario, inline checks.
module tb_cpu_irq_controller;

  localparam int unsigned NUM_SRC = 8;

  logic               clock = 1'b0;
  logic               reset_n;
  logic [NUM_SRC-1:0] irq_src;
  logic               bus_req, bus_write;
  logic [3:0]         bus_addr;
  logic [31:0]        bus_wdata, bus_rdata;
  logic               bus_ack, cpu_irq, cpu_irq_ack, cpu_irq_done;
  logic [7:0]         cpu_irq_cause;

  int passed = 0;
  int total  = 0;
  logic [31:0] rd;
  logic        rd_ack;

  cpu_irq_controller #(.NUM_SRC(NUM_SRC)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .irq_src       (irq_src),
    .bus_req       (bus_req),
    .bus_write     (bus_write),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .bus_ack       (bus_ack),
    .cpu_irq       (cpu_irq),
    .cpu_irq_cause (cpu_irq_cause),
    .cpu_irq_ack   (cpu_irq_ack),
    .cpu_irq_done  (cpu_irq_done)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    bus_req = 1'b1; bus_write = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
    bus_req = 1'b0; bus_write = 1'b0; bus_wdata = '0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d, output logic ack);
    bus_req = 1'b1; bus_write = 1'b0; bus_addr = a;
    tick();
    bus_req = 1'b0;
    d   = bus_rdata;
    ack = bus_ack;
  endtask

  task automatic pulse_ack();
    cpu_irq_ack = 1'b1; tick(); cpu_irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    cpu_irq_done = 1'b1; tick(); cpu_irq_done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    total++; if (cpu_irq !== 1'b0) $display("FAIL rst_irq got %b exp 0", cpu_irq); else passed++;
    total++; if (cpu_irq_cause !== 8'h00) $display("FAIL rst_cause got %h exp 00", cpu_irq_cause); else passed++;
    total++; if (bus_ack !== 1'b0) $display("FAIL rst_ack got %b exp 0", bus_ack); else passed++;
    total++; if (bus_rdata !== 32'h0) $display("FAIL rst_rdata got %h exp 0", bus_rdata); else passed++;
    bus_rd(4'd3, rd, rd_ack);
    total++; if (rd_ack !== 1'b1) $display("FAIL rst_bus_ack got %b exp 1", rd_ack); else passed++;
    total++; if (rd !== 32'h0) $display("FAIL rst_status got %h exp 0", rd); else passed++;
  endtask

  task automatic test_edge_src3();
    bus_wr(4'd1, 32'h08);
    bus_wr(4'd2, 32'h08);
    irq_src[3] = 1'b1; tick(); irq_src[3] = 1'b0;
    tick(3);
    total++; if (cpu_irq !== 1'b0) $display("FAIL edge_early got %b exp 0", cpu_irq); else passed++;
    tick();
    total++; if (cpu_irq !== 1'b1) $display("FAIL edge_req got %b exp 1", cpu_irq); else passed++;
    total++; if (cpu_irq_cause !== 8'h13) $display("FAIL edge_cause got %h exp 13", cpu_irq_cause); else passed++;
    bus_rd(4'd3, rd, rd_ack);
    total++; if (rd !== 32'h130) $display("FAIL edge_status_req got %h exp 130", rd); else passed++;
    pulse_ack();
    total++; if (cpu_irq !== 1'b0) $display("FAIL edge_ack_drop got %b exp 0", cpu_irq); else passed++;
    bus_rd(4'd0, rd, rd_ack);
    total++; if (rd !== 32'h0) $display("FAIL edge_pend_after_ack got %h exp 0", rd); else passed++;
    bus_rd(4'd3, rd, rd_ack);
    total++; if (rd !== 32'h230) $display("FAIL edge_status_svc got %h exp 230", rd); else passed++;
    pulse_done();
    bus_rd(4'd3, rd, rd_ack);
    total++; if (rd !== 32'h030) $display("FAIL edge_status_idle got %h exp 030", rd); else passed++;
    bus_wr(4'd1, 32'h0);
    bus_wr(4'd2, 32'h0);
  endtask

  task automatic test_priority();
    bus_wr(4'd1, 32'hFF);
    bus_rd(4'd1, rd, rd_ack);
    total++; if (rd !== 32'hFF) $display("FAIL prio_enable_rd got %h exp ff", rd); else passed++;
    irq_src[5] = 1'b1; irq_src[2] = 1'b1;
    tick(5);
    total++; if (cpu_irq !== 1'b1) $display("FAIL prio_req got %b exp 1", cpu_irq); else passed++;
    total++; if (cpu_irq_cause !== 8'h12) $display("FAIL prio_cause got %h exp 12", cpu_irq_cause); else passed++;
    irq_src[2] = 1'b0;
    tick(4);
    pulse_ack();
    pulse_done();
    total++; if (cpu_irq !== 1'b0) $display("FAIL prio_done_cycle got %b exp 0", cpu_irq); else passed++;
    tick();
    total++; if (cpu_irq !== 1'b1) $display("FAIL prio_rereq got %b exp 1", cpu_irq); else passed++;
    total++; if (cpu_irq_cause !== 8'h15) $display("FAIL prio_cause2 got %h exp 15", cpu_irq_cause); else passed++;
    irq_src[5] = 1'b0;
    tick(4);
    pulse_ack();
    pulse_done();
    bus_wr(4'd1, 32'h0);
  endtask

  task automatic test_masking();
    bus_wr(4'd2, 32'h02);
    irq_src[1] = 1'b1; tick(); irq_src[1] = 1'b0;
    tick(5);
    total++; if (cpu_irq !== 1'b0) $display("FAIL mask_irq got %b exp 0", cpu_irq); else passed++;
    bus_rd(4'd0, rd, rd_ack);
    total++; if (rd !== 32'h02) $display("FAIL mask_pend got %h exp 02", rd); else passed++;
    bus_wr(4'd1, 32'h02);
    total++; if (cpu_irq !== 1'b0) $display("FAIL mask_wr_cycle got %b exp 0", cpu_irq); else passed++;
    tick();
    total++; if (cpu_irq !== 1'b1) $display("FAIL mask_unmask got %b exp 1", cpu_irq); else passed++;
    total++; if (cpu_irq_cause !== 8'h11) $display("FAIL mask_cause got %h exp 11", cpu_irq_cause); else passed++;
    pulse_ack();
    pulse_done();
    bus_wr(4'd1, 32'h0);
    bus_wr(4'd2, 32'h0);
  endtask

  task automatic test_set_wins();
    bus_wr(4'd2, 32'h01);
    irq_src[0] = 1'b1; tick(); irq_src[0] = 1'b0;
    tick(4);
    bus_rd(4'd0, rd, rd_ack);
    total++; if (rd !== 32'h01) $display("FAIL sw_pend_first got %h exp 01", rd); else passed++;
    // Second rise: rise pulse is presented at the third edge after the line goes high.
    irq_src[0] = 1'b1; tick(); irq_src[0] = 1'b0;
    tick(2);
    bus_wr(4'd0, 32'h01);
    bus_rd(4'd0, rd, rd_ack);
    total++; if (rd !== 32'h01) $display("FAIL sw_set_wins got %h exp 01", rd); else passed++;
    bus_wr(4'd0, 32'h01);
    bus_rd(4'd0, rd, rd_ack);
    total++; if (rd !== 32'h00) $display("FAIL sw_w1c got %h exp 00", rd); else passed++;
    bus_wr(4'd2, 32'h0);
  endtask

  task automatic test_held();
    bus_wr(4'd1, 32'h10);
    irq_src[4] = 1'b1;
    tick(5);
    total++; if (cpu_irq_cause !== 8'h14) $display("FAIL held_cause got %h exp 14", cpu_irq_cause); else passed++;
    irq_src[4] = 1'b0;
    pulse_done();
    tick(4);
    bus_wr(4'd1, 32'h0);
    total++; if (cpu_irq !== 1'b1) $display("FAIL held_irq got %b exp 1", cpu_irq); else passed++;
    total++; if (cpu_irq_cause !== 8'h14) $display("FAIL held_cause2 got %h exp 14", cpu_irq_cause); else passed++;
    pulse_ack();
    total++; if (cpu_irq !== 1'b0) $display("FAIL held_ack got %b exp 0", cpu_irq); else passed++;
    pulse_done();
    bus_rd(4'd3, rd, rd_ack);
    total++; if (rd !== 32'h040) $display("FAIL held_status got %h exp 040", rd); else passed++;
  endtask

  task automatic test_reset_mid();
    bus_wr(4'd1, 32'h08);
    bus_wr(4'd2, 32'h08);
    irq_src[3] = 1'b1; tick(); irq_src[3] = 1'b0;
    tick(4);
    pulse_ack();
    bus_rd(4'd3, rd, rd_ack);
    total++; if (rd !== 32'h230) $display("FAIL rm_in_service got %h exp 230", rd); else passed++;
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    total++; if (cpu_irq !== 1'b0) $display("FAIL rm_irq got %b exp 0", cpu_irq); else passed++;
    for (int a = 0; a < 4; a++) begin
      bus_rd(4'(a), rd, rd_ack);
      total++; if (rd !== 32'h0) $display("FAIL rm_reg%0d got %h exp 0", a, rd); else passed++;
    end
  endtask

  initial begin
    reset_n = 1'b0; irq_src = '0; bus_req = 1'b0; bus_write = 1'b0;
    bus_addr = '0; bus_wdata = '0; cpu_irq_ack = 1'b0; cpu_irq_done = 1'b0;
    test_reset();
    test_edge_src3();
    test_priority();
    test_masking();
    test_set_wins();
    test_held();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
